// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector multiply scheduler: state
// encodings, default geometry and address-width helper.
package mvm_pkg;

  localparam int DEF_M       = 3;
  localparam int DEF_N       = 3;
  localparam int DEF_MAC_LAT = 3;

  // Scheduler states, kept as plain constants so older code can compare them.
  typedef logic [2:0] sched_state_t;

  localparam sched_state_t ST_IDLE      = 3'd0;
  localparam sched_state_t ST_ISSUE     = 3'd1;
  localparam sched_state_t ST_WAIT      = 3'd2;
  localparam sched_state_t ST_WRITE     = 3'd3;
  localparam sched_state_t ST_DRAIN_RD  = 3'd4;
  localparam sched_state_t ST_DRAIN_OUT = 3'd5;

  // Address width for a memory of the given depth; never below one bit so a
  // degenerate 1-deep memory still gets a legal port.
  function automatic int addr_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mvm_addr_gen.sv
// Row/column counters for the MAC schedule and the registered A/x read
// addresses derived from them (addr_a = r*N + k, addr_x = k).
module mvm_addr_gen
  import mvm_pkg::*;
#(
  parameter int M    = DEF_M,
  parameter int N    = DEF_N,
  parameter int AW_A = addr_width(M * N),
  parameter int AW_X = addr_width(N),
  parameter int AW_Y = addr_width(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,       // restart both counters at row 0, column 0
  input  logic            k_inc_i,     // step to the next column of the current row
  input  logic            row_next_i,  // step to the next row, column back to 0
  output logic [AW_Y-1:0] r_o,
  output logic            r_last_o,
  output logic            k_last_o,
  output logic [AW_A-1:0] addr_a_o,
  output logic [AW_X-1:0] addr_x_o
);

  logic [AW_Y-1:0] r_q, r_d;
  logic [AW_X-1:0] k_q, k_d;
  logic [AW_A-1:0] addr_a_q, addr_a_d;
  logic [AW_X-1:0] addr_x_q, addr_x_d;

  assign r_o      = r_q;
  assign r_last_o = (r_q == AW_Y'(M - 1));
  assign k_last_o = (k_q == AW_X'(N - 1));
  assign addr_a_o = addr_a_q;
  assign addr_x_o = addr_x_q;

  // Next counter values; both counters saturate at their last index.
  always_comb begin
    r_d = r_q;
    k_d = k_q;
    if (clr_i) begin
      r_d = '0;
      k_d = '0;
    end else if (row_next_i) begin
      if (r_q != AW_Y'(M - 1)) begin
        r_d = r_q + AW_Y'(1);
      end else begin
        r_d = r_q;
      end
      k_d = '0;
    end else if (k_inc_i) begin
      if (k_q != AW_X'(N - 1)) begin
        k_d = k_q + AW_X'(1);
      end else begin
        k_d = k_q;
      end
    end else begin
      r_d = r_q;
      k_d = k_q;
    end
    // Addresses follow the next counter values so they are valid in the
    // same cycle the counters are.
    addr_a_d = AW_A'(r_d) * AW_A'(N) + AW_A'(k_d);
    addr_x_d = k_d;
  end

  // Counter and address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= '0;
      k_q      <= '0;
      addr_a_q <= '0;
      addr_x_q <= '0;
    end else begin
      r_q      <= r_d;
      k_q      <= k_d;
      addr_a_q <= addr_a_d;
      addr_x_q <= addr_x_d;
    end
  end

endmodule

// File: rtl/mvm_scheduler.sv
// Sequencer for y = A*x: issues A/x reads row by row into a shared MAC,
// waits out the MAC latency, writes each row result into y with its
// overflow flag, then drains y through a valid/ready port.
module mvm_scheduler
  import mvm_pkg::*;
#(
  parameter int M       = DEF_M,
  parameter int N       = DEF_N,
  parameter int MAC_LAT = DEF_MAC_LAT,
  parameter int AW_A    = addr_width(M * N),
  parameter int AW_X    = addr_width(N),
  parameter int AW_Y    = addr_width(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [AW_A-1:0] addr_a,
  output logic [AW_X-1:0] addr_x,
  output logic            mac_valid_in,
  output logic            mac_clear,
  input  logic            mac_ovf,
  output logic            wr_en_y,
  output logic [AW_Y-1:0] addr_y,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            y_ovf
);

  // WAIT loads MAC_LAT and leaves when the counter reads zero: MAC_LAT+1 cycles.
  localparam int WCW = addr_width(MAC_LAT + 1);

  sched_state_t    state_q, state_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [M-1:0]    ovf_vec_q, ovf_vec_d;
  logic [AW_Y-1:0] addr_y_q, addr_y_d;
  logic            done_d;
  logic            busy_q, done_q, mac_valid_in_q, mac_clear_q, wr_en_y_q;

  logic            cnt_clr_s;
  logic            k_inc_s;
  logic            row_next_s;
  logic [AW_Y-1:0] r_s;
  logic            r_last_s;
  logic            k_last_s;

  mvm_addr_gen #(
    .M    (M),
    .N    (N),
    .AW_A (AW_A),
    .AW_X (AW_X),
    .AW_Y (AW_Y)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (cnt_clr_s),
    .k_inc_i    (k_inc_s),
    .row_next_i (row_next_s),
    .r_o        (r_s),
    .r_last_o   (r_last_s),
    .k_last_o   (k_last_s),
    .addr_a_o   (addr_a),
    .addr_x_o   (addr_x)
  );

  // Next-state, counter controls, overflow capture and y addressing.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ovf_vec_d  = ovf_vec_q;
    addr_y_d   = addr_y_q;
    done_d     = 1'b0;
    cnt_clr_s  = 1'b0;
    k_inc_s    = 1'b0;
    row_next_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ISSUE;
          cnt_clr_s = 1'b1;
          ovf_vec_d = '0;
          addr_y_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (k_last_s) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCW'(MAC_LAT);
        end else begin
          k_inc_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d  = ST_WRITE;
          addr_y_d = r_s;
        end else begin
          wait_cnt_d = wait_cnt_q - WCW'(1);
        end
      end
      ST_WRITE: begin
        ovf_vec_d[r_s] = mac_ovf;
        if (r_last_s) begin
          state_d  = ST_DRAIN_RD;
          addr_y_d = '0;
        end else begin
          state_d    = ST_ISSUE;
          row_next_s = 1'b1;
        end
      end
      ST_DRAIN_RD: begin
        state_d = ST_DRAIN_OUT;
      end
      ST_DRAIN_OUT: begin
        if (m_ready) begin
          if (addr_y_q == AW_Y'(M - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_DRAIN_RD;
            addr_y_d = addr_y_q + AW_Y'(1);
          end
        end else begin
          state_d = ST_DRAIN_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered strobes; strobes are decoded from the next state so
  // they are asserted during the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wait_cnt_q     <= '0;
      ovf_vec_q      <= '0;
      addr_y_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mac_valid_in_q <= 1'b0;
      mac_clear_q    <= 1'b0;
      wr_en_y_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      ovf_vec_q      <= ovf_vec_d;
      addr_y_q       <= addr_y_d;
      busy_q         <= (state_d != ST_IDLE);
      done_q         <= done_d;
      // One cycle behind ISSUE to line up with the registered A/x read data.
      mac_valid_in_q <= (state_q == ST_ISSUE);
      mac_clear_q    <= (state_d == ST_WRITE);
      wr_en_y_q      <= (state_d == ST_WRITE);
    end
  end

  // Output handshake decode: valid only while presenting a word.
  always_comb begin
    if (state_q == ST_DRAIN_OUT) begin
      m_valid = 1'b1;
      y_ovf   = ovf_vec_q[addr_y_q];
    end else begin
      m_valid = 1'b0;
      y_ovf   = 1'b0;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mac_valid_in = mac_valid_in_q;
  assign mac_clear    = mac_clear_q;
  assign wr_en_y      = wr_en_y_q;
  assign addr_y       = addr_y_q;

endmodule

// File: doc/mvm_scheduler.md
# mvm_scheduler

Sequencer that shares one MAC unit and three registered-read memories (matrix A, vector x, result y) to compute y = A·x for an M×N matrix. It sits between the load logic that fills A and x and the downstream consumer of y. Once A and x are loaded it runs the multiply-accumulate schedule row by row, writes each result and its overflow flag into y, then drains y through a valid/ready output port.

## Interface
Parameters:
- M, 3, matrix rows / y length
- N, 3, matrix columns / x length
- MAC_LAT, 3, cycles from the last mac_valid_in to a stable accumulator result on mac_result
- AW_A, $clog2(M*N), A address width
- AW_X, $clog2(N), x address width
- AW_Y, $clog2(M), y address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a computation; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last output handshake
- addr_a  out  AW_A  A memory read address
- addr_x  out  AW_X  x memory read address
- mac_valid_in  out  1  A/x read data valid this cycle
- mac_clear  out  1  clear the MAC accumulator
- mac_ovf  in  1  MAC overflow flag for the current row, stable by the end of WAIT
- wr_en_y  out  1  write mac_result into y[addr_y]
- addr_y  out  AW_Y  y memory address, shared by writes and reads
- m_valid  out  1  y read data on the y memory output is valid
- m_ready  in  1  consumer accepts
- y_ovf  out  1  overflow flag for the word currently presented

## Operation
- States: IDLE, ISSUE, WAIT, WRITE, DRAIN_RD, DRAIN_OUT.
- IDLE → ISSUE on start. Clear the row counter r, the column counter k and ovf_vec[M-1:0].
- ISSUE, lasting N cycles: addr_a = r·N+k and addr_x = k. k increments each cycle. After k = N-1, go to WAIT.
- mac_valid_in is a registered copy of (state==ISSUE). It is high for N cycles, delayed by one cycle, so it lines up with the registered memory read data.
- WAIT, lasting MAC_LAT+1 cycles, counted by a down-counter: no memory or MAC activity. Then go to WRITE.
- WRITE, 1 cycle: wr_en_y=1, addr_y=r, mac_clear=1, ovf_vec[r] ← mac_ovf.
  - If r = M-1, go to DRAIN_RD with addr_y=0.
  - Otherwise r++, k=0, go to ISSUE.
- DRAIN_RD, 1 cycle: present addr_y; m_valid=0. Then go to DRAIN_OUT.
- DRAIN_OUT: m_valid=1 and y_ovf=ovf_vec[addr_y]. addr_y is held until m_valid && m_ready.
  - On a handshake with addr_y = M-1: go to IDLE and pulse done in the next cycle.
  - On a handshake otherwise: addr_y++, go to DRAIN_RD.
- start is ignored while busy. m_ready is ignored outside DRAIN_OUT.
- Address counters saturate at their final value and never wrap inside a phase.

## Timing
- Reset value of every output is 0; state is IDLE.
- reset asserted mid-operation: return to IDLE on the next edge and drop all strobes. mac_clear is not asserted by reset itself.
- Compute latency from the start-accepted edge to the final WRITE: M·(N+MAC_LAT+2) cycles. For defaults: 24 cycles, WRITE cycles at 8, 16 and 24.
- Drain: minimum 2 cycles per word (one bubble per word). Output data on the y memory output is stable while m_valid=1 and m_ready=0.
- mac_clear and wr_en_y coincide. The MAC samples its result before the clear takes effect.
- All outputs are registered except m_valid and y_ovf, which are decoded from state and ovf_vec.

## Structure
- Shared package mvm_pkg holds:
  - the state enum sched_state_t;
  - default M, N and MAC_LAT constants;
  - localparam functions for the address widths.
- The datapath memories and the MAC are reused unchanged.
- One natural sub-module: mvm_addr_gen, holding the r/k counters and the addr_a multiply-add. It is instantiated once.

## Test plan
- Reset, then start=1 for one cycle with M=N=3, MAC_LAT=3 → busy=1 next cycle. addr_a sequence 0,1,2 | 3,4,5 | 6,7,8. mac_valid_in high for 3 cycles per row. wr_en_y at cycles 8, 16 and 24 with addr_y 0, 1, 2.
- A=[1,-8,3;9,-5,11;-7,8,-9], x=[1,-22,3], m_ready tied 1 → outputs 186, 152, -210 with y_ovf=0. done pulses exactly once.
- A rows of 127 with x=[127,127,127], mac_ovf forced 1 for row 1 only → y_ovf=1 on word 1 only.
- Randomised m_ready, 30% duty → addr_y and the y output stay stable while stalled. No word is skipped or duplicated.
- start pulsed during WAIT → no effect on the sequence or the count.
- reset asserted in ISSUE of row 1 → IDLE next cycle and all outputs 0. A new start then completes correctly.
